// File: rtl/ftrace_pkg.sv
// Shared types for the function-trace monitor: event kinds and the queued event record.
package ftrace_pkg;

    localparam int KIND_W  = 2;
    localparam int DEPTH_W = 5;

    typedef enum logic [KIND_W-1:0] {
        KIND_CALL          = 2'd0,
        KIND_RET           = 2'd1,
        KIND_RET_MISMATCH  = 2'd2,
        KIND_RET_UNDERFLOW = 2'd3
    } kind_e;

    typedef struct packed {
        kind_e              kind;
        logic [31:0]        pc;
        logic [31:0]        target;
        logic [5:0]         rd;
        logic [DEPTH_W-1:0] depth;
    } event_t;

endpackage

// File: rtl/ftrace_fifo.sv
// Synchronous FIFO of classified trace events; a push while full is accepted only
// when the head is popped in the same cycle.
module ftrace_fifo
    import ftrace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push_i,
    input  event_t push_data_i,
    input  logic   pop_i,
    output event_t head_o,
    output logic   empty_o,
    output logic   full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    event_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the occupancy count decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Mask the head while empty so outputs read as zero after reset.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ftrace_monitor.sv
// Function-trace monitor: shadow return-address stack, return classification,
// sticky error flags, drop counter and a valid/ready event queue.
module ftrace_monitor
    import ftrace_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ev_valid,
    input  logic               ev_is_call,
    input  logic [31:0]        ev_pc,
    input  logic [31:0]        ev_target,
    input  logic [5:0]         ev_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [KIND_W-1:0]  out_kind,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_target,
    output logic [5:0]         out_rd,
    output logic [DEPTH_W-1:0] out_depth,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow,
    output logic [15:0]        drop_cnt
);

    localparam int SP_W = $clog2(STACK_DEPTH);

    logic [31:0]        stack_q [STACK_DEPTH];
    logic [SP_W-1:0]    sp_q, sp_d, top_idx;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic [15:0]        drop_q, drop_d;
    logic               push_en, stack_full, stack_empty;
    logic               fifo_full, fifo_empty, fifo_pop, fifo_accept;
    logic [31:0]        top_addr;
    event_t             ev_cls, head;

    assign top_idx     = sp_q - SP_W'(1);
    assign top_addr    = stack_q[top_idx];
    assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);
    assign fifo_pop    = ~fifo_empty & out_ready;
    assign fifo_accept = ~fifo_full | fifo_pop;

    always_comb begin
        sp_d          = sp_q;
        depth_d       = depth_q;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;
        drop_d        = drop_q;
        push_en       = 1'b0;
        ev_cls.kind   = KIND_CALL;
        ev_cls.pc     = ev_pc;
        ev_cls.target = ev_target;
        ev_cls.rd     = ev_rd;
        ev_cls.depth  = depth_q;

        if (ev_valid) begin
            if (ev_is_call) begin
                // A full stack wraps: sp already points at the oldest entry.
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                if (stack_full) overflow_d = 1'b1;
                else            depth_d    = depth_q + DEPTH_W'(1);
                ev_cls.depth = stack_full ? depth_q : depth_q + DEPTH_W'(1);
            end else if (stack_empty) begin
                ev_cls.kind = KIND_RET_UNDERFLOW;
                underflow_d = 1'b1;
            end else begin
                sp_d        = top_idx;
                depth_d     = depth_q - DEPTH_W'(1);
                ev_cls.kind = (top_addr == ev_target) ? KIND_RET : KIND_RET_MISMATCH;
            end

            if (!fifo_accept && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp_q        <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            drop_q      <= drop_d;
        end
    end

    // Register-based stack: a pop in the cycle after a push reads the freshly written entry.
    always_ff @(posedge clock) begin
        if (push_en) stack_q[sp_q] <= ev_pc + 32'd4;
    end

    ftrace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (ev_valid),
        .push_data_i (ev_cls),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign out_valid  = ~fifo_empty;
    assign out_kind   = head.kind;
    assign out_pc     = head.pc;
    assign out_target = head.target;
    assign out_rd     = head.rd;
    assign out_depth  = head.depth;
    assign depth      = depth_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_ftrace_monitor.sv
// Self-checking bench for ftrace_monitor: a reference stack/queue model pushes expected
// events into a scoreboard which is popped at each output handshake.
module tb_ftrace_monitor;
    import ftrace_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ev_valid, ev_is_call, out_ready;
    logic [31:0] ev_pc, ev_target;
    logic [5:0]  ev_rd;
    logic        out_valid, overflow, underflow;
    logic [1:0]  out_kind;
    logic [31:0] out_pc, out_target;
    logic [5:0]  out_rd;
    logic [4:0]  out_depth, depth;
    logic [15:0] drop_cnt;

    always #5 clock = ~clock;

    ftrace_monitor #(.STACK_DEPTH(16), .FIFO_DEPTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .ev_valid   (ev_valid),
        .ev_is_call (ev_is_call),
        .ev_pc      (ev_pc),
        .ev_target  (ev_target),
        .ev_rd      (ev_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kind   (out_kind),
        .out_pc     (out_pc),
        .out_target (out_target),
        .out_rd     (out_rd),
        .out_depth  (out_depth),
        .depth      (depth),
        .overflow   (overflow),
        .underflow  (underflow),
        .drop_cnt   (drop_cnt)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pop    = 0;
    event_t      sb[$];
    logic [31:0] mstk[$];
    int          occ   = 0;
    int          mdrop = 0;
    bit          movf  = 0;
    bit          munf  = 0;
    event_t      mon_exp;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: the handshake seen here completes at the next rising edge.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    check("sb_spurious", 1, 0);
                end else begin
                    mon_exp = sb.pop_front();
                    check("event", {out_kind, out_pc, out_target, out_rd, out_depth}, mon_exp);
                end
            end
        end
    end

    task automatic upd_occ(input bit pushed);
        int popped;
        popped = (occ > 0 && out_ready) ? 1 : 0;
        occ    = occ + (pushed ? 1 : 0) - popped;
    endtask

    task automatic check_state();
        check("depth", depth, mstk.size());
        check("overflow", overflow, movf);
        check("underflow", underflow, munf);
        check("drop_cnt", drop_cnt, mdrop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            upd_occ(1'b0);
        end
    endtask

    // Drive one event for one cycle; called at posedge+1.
    task automatic send(input bit call, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [5:0] rd);
        event_t      e;
        logic [31:0] a;
        bit          pushed;
        e.pc     = pc;
        e.target = tgt;
        e.rd     = rd;
        if (call) begin
            if (mstk.size() == 16) begin
                void'(mstk.pop_front());
                movf = 1;
            end
            mstk.push_back(pc + 32'd4);
            e.kind  = KIND_CALL;
            e.depth = 5'(mstk.size());
        end else if (mstk.size() == 0) begin
            e.kind  = KIND_RET_UNDERFLOW;
            e.depth = 5'd0;
            munf    = 1;
        end else begin
            e.depth = 5'(mstk.size());
            a       = mstk.pop_back();
            e.kind  = (a == tgt) ? KIND_RET : KIND_RET_MISMATCH;
        end
        pushed = (occ < 8) || out_ready;
        if (pushed) sb.push_back(e);
        else if (mdrop < 16'hFFFF) mdrop++;

        ev_valid   = 1'b1;
        ev_is_call = call;
        ev_pc      = pc;
        ev_target  = tgt;
        ev_rd      = rd;
        @(posedge clock);
        #1;
        ev_valid = 1'b0;
        upd_occ(pushed);
        check_state();
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && occ == 0) break;
            idle(1);
        end
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_valid", out_valid, 0);
    endtask

    initial begin
        int snap;
        reset      = 1'b1;
        ev_valid   = 1'b0;
        ev_is_call = 1'b0;
        ev_pc      = '0;
        ev_target  = '0;
        ev_rd      = '0;
        out_ready  = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_fields", {out_kind, out_pc, out_target, out_rd, out_depth}, 0);
        check("rst_depth", depth, 0);
        check("rst_flags", {overflow, underflow}, 0);
        check("rst_drop", drop_cnt, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;

        // Matched call/return.
        send(1'b1, 32'h8000_0000, 32'h1000_0000, 6'd1);
        send(1'b0, 32'h1000_0040, 32'h8000_0004, 6'd0);
        drain();
        check("match_depth", depth, 0);
        check("match_flags", {overflow, underflow}, 0);

        // Mismatched return, then pc wrap-around on the pushed return address.
        send(1'b1, 32'h8000_0010, 32'h2000_0000, 6'd1);
        send(1'b0, 32'h2000_0010, 32'h8000_0100, 6'd0);
        send(1'b1, 32'hFFFF_FFFC, 32'h3000_0000, 6'd5);
        send(1'b0, 32'h3000_0008, 32'h0000_0000, 6'd0);
        drain();
        check("mismatch_depth", depth, 0);

        // Underflow, then a normal pair still matches.
        send(1'b0, 32'h4000_0000, 32'h4000_1234, 6'd0);
        check("underflow_flag", underflow, 1);
        send(1'b1, 32'h5000_0000, 32'h6000_0000, 6'd1);
        send(1'b0, 32'h6000_0004, 32'h5000_0004, 6'd0);
        drain();

        // Overflow: 17 calls, 16 matching returns, then one more return underflows.
        for (int i = 0; i <= 16; i++) send(1'b1, 32'(i * 32'h100), 32'h7000_0000, 6'(i));
        check("ovf_flag", overflow, 1);
        check("ovf_depth", depth, 16);
        for (int i = 16; i >= 1; i--) send(1'b0, 32'h7000_0010, 32'(i * 32'h100 + 4), 6'd0);
        send(1'b0, 32'h7000_0010, 32'h0000_0004, 6'd0);
        drain();

        // Backpressure: 10 events into an 8-deep queue, then push while popping at full.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(1'b0, 32'h9000_0000 + 32'(i), 32'h0, 6'(i));
        check("bp_drop", drop_cnt, 2);
        check("bp_valid", out_valid, 1);
        out_ready = 1'b1;
        send(1'b1, 32'hA000_0000, 32'h0, 6'd33);
        out_ready = 1'b0;
        snap = n_pop;
        idle(1);
        drain();
        check("bp_drain_count", n_pop - snap, 8);

        // Random traffic with random backpressure.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] tgt;
            bit          call;
            out_ready = 1'($urandom_range(0, 1));
            call      = ($urandom_range(0, 2) != 0);
            tgt       = $urandom;
            if (!call && mstk.size() > 0 && $urandom_range(0, 3) != 0) tgt = mstk[$];
            send(call, $urandom, tgt, 6'($urandom));
        end
        drain();

        // Asynchronous reset in the middle of a burst.
        out_ready = 1'b0;
        send(1'b1, 32'hB000_0000, 32'h0, 6'd1);
        send(1'b1, 32'hB000_0100, 32'h0, 6'd2);
        ev_valid   = 1'b1;
        ev_is_call = 1'b1;
        ev_pc      = 32'hB000_0200;
        #3;
        reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_depth", depth, 0);
        check("arst_drop", drop_cnt, 0);
        check("arst_flags", {overflow, underflow}, 0);
        ev_valid = 1'b0;
        sb.delete();
        mstk.delete();
        occ   = 0;
        mdrop = 0;
        movf  = 0;
        munf  = 0;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        send(1'b1, 32'hC000_0000, 32'hD000_0000, 6'd3);
        send(1'b0, 32'hD000_0004, 32'hC000_0004, 6'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ftrace_monitor.md
# ftrace_monitor

Hardware consumer of the per-instruction function-trace events that the core produces on every call/return (jal/jalr with `func_flag`). It keeps a shadow return-address stack, classifies each return as matched, mismatched or underflowing, and queues classified events into a small FIFO. A valid/ready drain port lets a trace sink or debug bus read the queue. The block sits beside the writeback stage in simulation and FPGA builds.

## Interface
- `STACK_DEPTH`, default 16: shadow-stack entries; power of two, at least 2.
- `FIFO_DEPTH`, default 8: event queue entries; power of two, at least 2.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `ev_valid` in 1: event strobe, one event per cycle maximum.
- `ev_is_call` in 1: 1 = call (jal/jalr linking), 0 = return.
- `ev_pc` in 32: pc of the call/return instruction.
- `ev_target` in 32: next pc after the instruction.
- `ev_rd` in 6: destination register index; carried through to the output.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: sink accepts the head.
- `out_kind` out 2: 0 CALL, 1 RET, 2 RET_MISMATCH, 3 RET_UNDERFLOW.
- `out_pc` out 32, `out_target` out 32, `out_rd` out 6: copies of the event fields.
- `out_depth` out 5: call depth attached to the event.
- `depth` out 5: current shadow-stack occupancy, 0..STACK_DEPTH.
- `overflow` out 1: sticky; set when a call is pushed onto a full stack.
- `underflow` out 1: sticky; set when a return arrives with depth 0.
- `drop_cnt` out 16: saturating count of events lost because the FIFO was full.

## Operation
- **Call** (`ev_valid & ev_is_call`):
  - Push `ev_pc+4` (mod 2^32) at `sp` and advance `sp` modulo STACK_DEPTH.
  - `depth` increments and saturates at STACK_DEPTH.
  - When depth is already STACK_DEPTH, the oldest entry is overwritten and `overflow` is set.
  - Kind is CALL; `out_depth` is the depth after the push.
- **Return** (`ev_valid & ~ev_is_call`):
  - If depth is 0: kind RET_UNDERFLOW, `underflow` set, stack unchanged, `out_depth` = 0.
  - Otherwise pop the top entry and decrement depth. Kind is RET if the popped address equals `ev_target`, else RET_MISMATCH. `out_depth` is the depth before the pop.
- **Enqueue:** every classified event is written to the FIFO.
  - The write is accepted when the FIFO is not full, or when it is full and the head is consumed in the same cycle.
  - Otherwise the event is dropped and `drop_cnt` increments, saturating at 0xFFFF.
  - Stack state updates whether or not the event is enqueued.
- **Drain:** the head is removed when `out_valid & out_ready`. Output fields are held stable while `out_valid & ~out_ready`.
- **Reset values:** `out_valid`=0, `out_kind`=0, all `out_*` fields=0, `depth`=0, `sp`=0, `overflow`=0, `underflow`=0, `drop_cnt`=0, FIFO empty. Stack RAM contents are don't-care.
- **Reset mid-operation:** queued events and stack contents are discarded immediately (asynchronous). There is no partial drain.

## Timing
- Classification is registered. An event accepted at edge N is visible on `out_*` with `out_valid`=1 after edge N when the FIFO was empty. Latency is 1 cycle.
- `depth`, `overflow`, `underflow` and `drop_cnt` update at the same edge that consumes the event.
- Back-to-back events are sustained at one per cycle. A call immediately followed by a return uses the just-pushed entry, so the stack needs write-then-read forwarding or a register-based implementation.
- Simultaneous push and pop of the FIFO keeps occupancy constant, at every occupancy including full and empty.
  - Push into an empty FIFO with `out_ready`=1 still takes 1 cycle; there is no combinational bypass.
- `out_valid` must not depend combinationally on `out_ready`.

## Structure
- `ftrace_pkg`: kind enum (CALL/RET/RET_MISMATCH/RET_UNDERFLOW), the 2-bit kind width, and an event record typedef {kind, pc, target, rd, depth}.
- Sub-module `ftrace_fifo`: a parameterised synchronous FIFO of event records with full, empty, push and pop, handling simultaneous push/pop at full.
- The shadow stack, classification logic and counters live in `ftrace_monitor`.

## Test plan
- **Call/return match:** call pc=0x80000000, then return target=0x80000004. Expect CALL with depth 1, then RET with depth 1; final `depth`=0; both flags 0.
- **Mismatch:** call pc=0x80000010, then return target=0x80000100. Expect RET_MISMATCH; `depth` ends at 0.
- **Underflow:** return at depth 0. Expect RET_UNDERFLOW, `underflow`=1, `depth`=0; a subsequent call/return pair still matches.
- **Overflow:**
  - 17 calls with pc=0x100·i. Expect `overflow`=1 and `depth`=16.
  - Then 16 matching returns in reverse order (targets 0x100·i+4 for i=16..1). Expect all RET.
  - A 17th return gives RET_UNDERFLOW.
- **Backpressure:**
  - Hold `out_ready`=0 and issue 10 events. Expect 8 queued and `drop_cnt`=2.
  - Next cycle, issue one event with `out_ready`=1. Expect it accepted and occupancy to stay 8.
- **Async reset:** assert `reset` mid-burst between clock edges. Expect `out_valid`=0 and `depth`=0 immediately, and `drop_cnt`=0.
